// File: rtl/modmul_pkg.sv
// modmul_pkg: shared widths, defaults and controller state encoding for the modular multiplier host.
package modmul_pkg;
  localparam int OP_W = 256;
  localparam int WORD_W = 32;
  localparam int N_WORDS = OP_W / WORD_W;
  localparam int TIMEOUT_CYC = 1024;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DRAIN} state_e;
endpackage

// File: rtl/modmul_word_shifter.sv
// modmul_word_shifter: full-width register with parallel load and right shift by one stream word.
module modmul_word_shifter #(
  parameter int OP_W = modmul_pkg::OP_W,
  parameter int WORD_W = modmul_pkg::WORD_W
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            shift_i,
  input  logic [OP_W-1:0] data_i,
  output logic [OP_W-1:0] q_o
);
  logic [OP_W-1:0] q_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) q_q <= '0;
    else if (load_i) q_q <= data_i;
    else if (shift_i) q_q <= q_q >> WORD_W;
  assign q_o = q_q;
endmodule

// File: rtl/modmul_host_ctrl.sv
// modmul_host_ctrl: assembles streamed operand words, runs one multiplier start/done handshake
// with a timeout, and streams the captured result back out least-significant word first.
module modmul_host_ctrl #(
  parameter int OP_W = modmul_pkg::OP_W,
  parameter int WORD_W = modmul_pkg::WORD_W,
  parameter int TIMEOUT_CYC = modmul_pkg::TIMEOUT_CYC
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WORD_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] out_data_o,
  output logic              mm_start_o,
  output logic [OP_W-1:0]   mm_x_o,
  output logic [OP_W-1:0]   mm_y_o,
  input  logic [OP_W-1:0]   mm_q_i,
  input  logic              mm_done_i,
  output logic              busy_o,
  output logic              timeout_err_o
);
  import modmul_pkg::*;
  localparam int N = OP_W / WORD_W;
  localparam int NW = $clog2(N);
  localparam int CW = NW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [TW-1:0]   tmo_q;
  logic [OP_W-1:0] x_q, y_q, res_q;
  logic            in_ready_q, out_valid_q, mm_start_q, busy_q, err_q;
  logic            in_fire, out_fire, cap;
  assign in_fire = in_valid_i & in_ready_q;
  assign out_fire = out_valid_q & out_ready_i;
  assign cap = (state_q == WAIT) & mm_done_i;
  // Outputs are registered alongside the state so they change on the same edge as the transition.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      tmo_q <= '0;
      x_q <= '0;
      y_q <= '0;
      in_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      mm_start_q <= 1'b0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      mm_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q <= LOAD;
          in_ready_q <= 1'b1;
        end
        LOAD: if (in_fire) begin
          err_q <= 1'b0;
          if (cnt_q[CW-1]) y_q[WORD_W*int'(cnt_q[NW-1:0]) +: WORD_W] <= in_data_i;
          else x_q[WORD_W*int'(cnt_q[NW-1:0]) +: WORD_W] <= in_data_i;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(2*N-1)) begin
            cnt_q <= '0;
            state_q <= START;
            in_ready_q <= 1'b0;
            mm_start_q <= 1'b1;
            busy_q <= 1'b1;
          end
        end
        START: begin
          state_q <= WAIT;
          tmo_q <= '0;
        end
        WAIT: if (mm_done_i) begin
          state_q <= DRAIN;
          out_valid_q <= 1'b1;
        end else if (tmo_q == TW'(TIMEOUT_CYC-1)) begin
          state_q <= LOAD;
          err_q <= 1'b1;
          in_ready_q <= 1'b1;
          busy_q <= 1'b0;
        end else tmo_q <= tmo_q + 1'b1;
        DRAIN: if (out_fire) begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N-1)) begin
            cnt_q <= '0;
            state_q <= LOAD;
            out_valid_q <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  modmul_word_shifter #(.OP_W(OP_W), .WORD_W(WORD_W)) u_res (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .load_i(cap),
    .shift_i(out_fire),
    .data_i(mm_q_i),
    .q_o(res_q)
  );
  assign in_ready_o = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o = res_q[WORD_W-1:0];
  assign mm_start_o = mm_start_q;
  assign mm_x_o = x_q;
  assign mm_y_o = y_q;
  assign busy_o = busy_q;
  assign timeout_err_o = err_q;
endmodule
